// File: rtl/vx_sched_pkg.sv
// Shared width helpers and tag layout for the DRAM scheduler.
// The requester index occupies the low bits of the outgoing DRAM tag.
package vx_sched_pkg;

    localparam int unsigned TAG_IDX_LSB = 0;

    function automatic int unsigned sel_bits(input int unsigned num_reqs);
        return (num_reqs > 1) ? unsigned'($clog2(num_reqs)) : 1;
    endfunction

    function automatic int unsigned tag_out_width(input int unsigned tag_in_width,
                                                  input int unsigned num_reqs);
        return tag_in_width + sel_bits(num_reqs);
    endfunction

endpackage

// File: rtl/vx_dram_sched_if.sv
// Request/response bundle between the per-core clients, the scheduler and the DRAM port.
// The scheduler uses the slave modport; the surrounding environment uses master.
interface vx_dram_sched_if #(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned TAG_IN_WIDTH = 8
) ();
    import vx_sched_pkg::*;

    localparam int unsigned TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_REQS);
    localparam int unsigned BYTEEN_WIDTH  = DATA_WIDTH / 8;

    logic [NUM_REQS-1:0]                   req_valid_in;
    logic [NUM_REQS-1:0]                   req_rw_in;
    logic [NUM_REQS-1:0][BYTEEN_WIDTH-1:0] req_byteen_in;
    logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]   req_addr_in;
    logic [NUM_REQS-1:0][DATA_WIDTH-1:0]   req_data_in;
    logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0] req_tag_in;
    logic [NUM_REQS-1:0]                   req_ready_in;

    logic                                  dram_req_valid;
    logic                                  dram_req_rw;
    logic [BYTEEN_WIDTH-1:0]               dram_req_byteen;
    logic [ADDR_WIDTH-1:0]                 dram_req_addr;
    logic [DATA_WIDTH-1:0]                 dram_req_data;
    logic [TAG_OUT_WIDTH-1:0]              dram_req_tag;
    logic                                  dram_req_ready;

    logic                                  dram_rsp_valid;
    logic [DATA_WIDTH-1:0]                 dram_rsp_data;
    logic [TAG_OUT_WIDTH-1:0]              dram_rsp_tag;
    logic                                  dram_rsp_ready;

    logic [NUM_REQS-1:0]                   rsp_valid_out;
    logic [NUM_REQS-1:0][DATA_WIDTH-1:0]   rsp_data_out;
    logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0] rsp_tag_out;
    logic [NUM_REQS-1:0]                   rsp_ready_out;

    logic                                  busy;

    modport slave (
        input  req_valid_in, req_rw_in, req_byteen_in, req_addr_in, req_data_in, req_tag_in,
        output req_ready_in,
        output dram_req_valid, dram_req_rw, dram_req_byteen, dram_req_addr, dram_req_data,
        output dram_req_tag,
        input  dram_req_ready,
        input  dram_rsp_valid, dram_rsp_data, dram_rsp_tag,
        output dram_rsp_ready,
        output rsp_valid_out, rsp_data_out, rsp_tag_out,
        input  rsp_ready_out,
        output busy
    );

    modport master (
        output req_valid_in, req_rw_in, req_byteen_in, req_addr_in, req_data_in, req_tag_in,
        input  req_ready_in,
        input  dram_req_valid, dram_req_rw, dram_req_byteen, dram_req_addr, dram_req_data,
        input  dram_req_tag,
        output dram_req_ready,
        output dram_rsp_valid, dram_rsp_data, dram_rsp_tag,
        input  dram_rsp_ready,
        input  rsp_valid_out, rsp_data_out, rsp_tag_out,
        output rsp_ready_out,
        input  busy
    );

endinterface

// File: rtl/vx_rr_arbiter.sv
// One-hot round-robin arbiter; the search starts at the pointer, which moves past the
// granted requester whenever the grant is consumed.
module vx_rr_arbiter
    import vx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQS = 4,
    localparam int unsigned SEL_BITS = sel_bits(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                advance,
    output logic [NUM_REQS-1:0] grant,
    output logic [SEL_BITS-1:0] grant_idx
);

    logic [SEL_BITS-1:0] ptr_q;

    always_comb begin : rr_search
        logic        found;
        int unsigned j;
        found     = 1'b0;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= NUM_REQS) begin
                j = j - NUM_REQS;
            end
            if (!found && requests[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = SEL_BITS'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_idx == SEL_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + SEL_BITS'(1);
        end
    end

endmodule

// File: rtl/vx_dram_sched.sv
// Credit-limited round-robin scheduler sharing one DRAM port among NUM_REQS clients.
// Define DRAM_SCHED_PERF_EN to add the credit-stall and port-stall performance counters.
module vx_dram_sched
    import vx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned TAG_IN_WIDTH = 8,
    parameter int unsigned MAX_PENDING  = 8
) (
    input  logic             clk,
    input  logic             reset,
    vx_dram_sched_if.slave   bus
`ifdef DRAM_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_credit_stalls,
    output logic [31:0]      perf_port_stalls
`endif
);

    localparam int unsigned SEL_BITS      = sel_bits(NUM_REQS);
    localparam int unsigned TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_REQS);
    localparam int unsigned BYTEEN_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH     = unsigned'($clog2(MAX_PENDING + 1));
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_PENDING);

    logic [NUM_REQS-1:0]      eligible, credit_block, grant, inc, dec;
    logic [SEL_BITS-1:0]      grant_idx, rsp_idx;
    logic                     load_en, fire, idx_ok, rsp_fire, any_pending;
    logic [CNT_WIDTH-1:0]     pending_q [NUM_REQS];
    logic [CNT_WIDTH-1:0]     pending_d [NUM_REQS];

    logic                     valid_q, rw_q;
    logic [BYTEEN_WIDTH-1:0]  byteen_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [TAG_OUT_WIDTH-1:0] tag_q;

    // Writes never consume credit, so only reads can be held back by a full counter.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            credit_block[i] = bus.req_valid_in[i] && !bus.req_rw_in[i]
                              && (pending_q[i] >= CNT_MAX);
            eligible[i]     = bus.req_valid_in[i] && !credit_block[i];
        end
    end

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .requests  (eligible),
        .advance   (fire),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign load_en          = !valid_q || bus.dram_req_ready;
    assign fire             = load_en && !reset && (|eligible);
    assign bus.req_ready_in = (load_en && !reset) ? grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            rw_q     <= 1'b0;
            byteen_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            tag_q    <= '0;
        end else if (load_en) begin
            valid_q <= fire;
            if (fire) begin
                rw_q     <= bus.req_rw_in[grant_idx];
                byteen_q <= bus.req_byteen_in[grant_idx];
                addr_q   <= bus.req_addr_in[grant_idx];
                data_q   <= bus.req_data_in[grant_idx];
                tag_q    <= {bus.req_tag_in[grant_idx], grant_idx};
            end
        end
    end

    assign bus.dram_req_valid  = valid_q;
    assign bus.dram_req_rw     = rw_q;
    assign bus.dram_req_byteen = byteen_q;
    assign bus.dram_req_addr   = addr_q;
    assign bus.dram_req_data   = data_q;
    assign bus.dram_req_tag    = tag_q;

    // Out-of-range indices are swallowed so a stray response cannot wedge the port.
    assign rsp_idx  = bus.dram_rsp_tag[TAG_IDX_LSB +: SEL_BITS];
    assign idx_ok   = 32'(rsp_idx) < NUM_REQS;
    assign rsp_fire = bus.dram_rsp_valid && bus.dram_rsp_ready && idx_ok && !reset;

    always_comb begin
        bus.rsp_valid_out  = '0;
        bus.dram_rsp_ready = 1'b1;
        if (idx_ok) begin
            bus.rsp_valid_out[rsp_idx] = bus.dram_rsp_valid && !reset;
            bus.dram_rsp_ready         = bus.rsp_ready_out[rsp_idx];
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            bus.rsp_data_out[i] = bus.dram_rsp_data;
            bus.rsp_tag_out[i]  = bus.dram_rsp_tag[TAG_OUT_WIDTH-1 -: TAG_IN_WIDTH];
        end
    end

    always_comb begin
        any_pending = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            inc[i]       = fire && grant[i] && !bus.req_rw_in[i];
            dec[i]       = rsp_fire && (rsp_idx == SEL_BITS'(i));
            pending_d[i] = pending_q[i];
            if (inc[i] && !dec[i]) begin
                pending_d[i] = pending_q[i] + CNT_WIDTH'(1);
            end else if (!inc[i] && dec[i] && (pending_q[i] != '0)) begin
                pending_d[i] = pending_q[i] - CNT_WIDTH'(1);
            end
            any_pending = any_pending || (pending_q[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                pending_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                pending_q[i] <= pending_d[i];
            end
        end
    end

    assign bus.busy = valid_q || any_pending;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                assert (!(dec[i] && !inc[i] && (pending_q[i] == '0)))
                    else $error("pending counter underflow on requester %0d", i);
            end
            assert (!(bus.dram_rsp_valid && !idx_ok))
                else $error("response index %0d out of range", rsp_idx);
        end
    end
`endif

`ifdef DRAM_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_credit_stalls <= '0;
            perf_port_stalls   <= '0;
        end else begin
            if (|credit_block) begin
                perf_credit_stalls <= perf_credit_stalls + 32'd1;
            end
            if (valid_q && !bus.dram_req_ready) begin
                perf_port_stalls <= perf_port_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/vx_dram_sched.md
Name: vx_dram_sched

Overview:
- Credit-limited round-robin scheduler sharing one DRAM request/response port among NUM_REQS per-core memory clients inside a cluster. Used on the no-L2 path.
- Appends the requester index to the outgoing tag and routes responses back by that index.
- Caps outstanding reads per requester so one core cannot monopolise the response queue.
- Registered request output; combinational response demux.

Parameters:
- NUM_REQS, 4, number of requesters (1..16).
- DATA_WIDTH, 512, line width in bits; byte-enable width is DATA_WIDTH/8.
- ADDR_WIDTH, 26, line address width.
- TAG_IN_WIDTH, 8, per-requester tag width.
- MAX_PENDING, 8, maximum outstanding reads per requester (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid_in  in  NUM_REQS  per-requester request valid
- req_rw_in  in  NUM_REQS  1 = write
- req_byteen_in  in  NUM_REQS x DATA_WIDTH/8  byte enables
- req_addr_in  in  NUM_REQS x ADDR_WIDTH  line address
- req_data_in  in  NUM_REQS x DATA_WIDTH  write data
- req_tag_in  in  NUM_REQS x TAG_IN_WIDTH  request tag
- req_ready_in  out  NUM_REQS  per-requester accept
- dram_req_valid  out  1  DRAM request valid
- dram_req_rw  out  1  write flag
- dram_req_byteen  out  DATA_WIDTH/8  byte enables
- dram_req_addr  out  ADDR_WIDTH  address
- dram_req_data  out  DATA_WIDTH  data
- dram_req_tag  out  TAG_OUT_WIDTH  {tag_in, req_idx}
- dram_req_ready  in  1  DRAM accept
- dram_rsp_valid  in  1  response valid
- dram_rsp_data  in  DATA_WIDTH  read data
- dram_rsp_tag  in  TAG_OUT_WIDTH  response tag
- dram_rsp_ready  out  1  response accept
- rsp_valid_out  out  NUM_REQS  per-requester response valid
- rsp_data_out  out  NUM_REQS x DATA_WIDTH  broadcast data
- rsp_tag_out  out  NUM_REQS x TAG_IN_WIDTH  original tag
- rsp_ready_out  in  NUM_REQS  per-requester response ready
- busy  out  1  any read pending or output register full

Behaviour:
- Widths: SEL_BITS = max(1, clog2(NUM_REQS)); TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS; pending counters are clog2(MAX_PENDING+1) bits.
- Reset (async, active-high) clears the output register (dram_req_valid = 0), all pending counters, and the RR pointer (to 0). Reset values: req_ready_in = 0, rsp_valid_out = 0, busy = 0. Any response arriving after a mid-operation reset is handled by the underflow rule below.
- Eligibility: eligible[i] = req_valid_in[i] && (req_rw_in[i] || pending[i] < MAX_PENDING). Writes never consume credit.
- Arbitration: round-robin one-hot grant over eligible, starting at the pointer. On a handshake the pointer moves to grant index + 1, mod NUM_REQS. When nothing is accepted the pointer holds.
- Output register: load_en = !dram_req_valid || dram_req_ready. req_ready_in[i] = grant[i] && load_en. The accepted request appears on dram_req_* the next cycle, i.e. latency 1 with full throughput under a continuous ready.
- Outputs are stable while dram_req_valid && !dram_req_ready. When load_en is set and no request is eligible, valid clears.
- Response routing: idx = dram_rsp_tag[SEL_BITS-1:0]. rsp_valid_out[idx] = dram_rsp_valid; dram_rsp_ready = rsp_ready_out[idx]; rsp_tag_out = upper tag bits; data is broadcast. Fully combinational, no bubble.
- Counters: pending[i] increments on an accepted read from i and decrements on a response handshake to i. Both in the same cycle leaves the counter unchanged. Decrement at 0 saturates at 0 and fires a simulation assertion.
- An idx >= NUM_REQS is dropped: dram_rsp_ready = 1, no valid asserted, assertion fires.
- busy = dram_req_valid || (|pending).

Optional Feature:
- Macro DRAM_SCHED_PERF_EN.
- Defined: adds outputs perf_credit_stalls (32) and perf_port_stalls (32).
  - perf_credit_stalls increments each cycle some req_valid_in is blocked solely by credit.
  - perf_port_stalls increments each cycle dram_req_valid && !dram_req_ready.
  - Both are cleared by reset and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package vx_sched_pkg holds the SEL_BITS/TAG_OUT_WIDTH helper functions and the tag-layout constant (index in LSBs).
- Sub-module vx_rr_arbiter: NUM_REQS-wide one-hot round-robin grant with pointer register, advance-on-fire input, and clk/async reset.

Test Plan:
- All 4 requesters issue back-to-back reads with dram_req_ready = 1 → grants in order 0,1,2,3,0…; dram_req_tag[1:0] matches the source; one request per cycle.
- Requester 2 issues 9 reads with responses withheld, MAX_PENDING = 8 → 8 accepted, 9th stalls (req_ready_in[2] = 0) until one response returns. Writes from 2 are still accepted.
- dram_req_ready held low for 5 cycles with a registered request → dram_req_* stable; no req_ready_in asserted.
- Response with tag {8'h5A, 2'd1} while rsp_ready_out[1] = 0 for 3 cycles → rsp_valid_out = 4'b0010 and dram_rsp_ready = 0 until ready rises; rsp_tag_out[1] = 8'h5A.
- Same-cycle read accept and response for requester 0 at pending = 3 → pending stays at 3.
- Reset asserted asynchronously mid-burst → outputs clear immediately; busy = 0; next grant starts at requester 0.
